// File: rtl/mem_pkg.sv
// Shared memory-map constants, byte type and responder FSM states.
// Imported by the responder and its byte RAM.
package mem_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } mem_state_t;

  // Platform layout agreed with the CPU: function table, then operand stack, call stack on top.
  localparam logic [31:0] FUNCTION_TABLE_BASE = 32'h0000_1000;
  localparam logic [31:0] OP_STACK_TOP        = 32'h0000_1800;
  localparam logic [31:0] CALL_STACK_TOP      = 32'h0000_1FFF;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port DEPTH x 8 RAM: synchronous write, registered read (one-edge latency).
// No backpressure; contents are not reset.
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  byte_t             i_wdata,
  output byte_t             o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  byte_t r_mem [DEPTH];
  byte_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Level-handshake byte memory responder: ready 1+WAIT_STATES edges after capture; writes commit on capture.
// Initiator holds enables until ready; optional MEM_BOUNDS_CHECK_EN flags and suppresses out-of-range accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in,
  input  logic        memory_read_en,
  input  logic        memory_write_en,
  output logic [7:0]  data_out,
  output logic        memory_ready,
  output logic        bus_error
);

  mem_state_t r_state;
  logic [3:0] r_cnt;
  logic [31:0] r_addr;
  byte_t      r_data;
  logic       r_wr;
  logic       r_oob;
  logic       r_ready;
  byte_t      r_dout;

  logic              w_rd;
  logic              w_wr;
  logic              w_req;
  logic              w_same;
  logic              w_start;
  logic              w_oob;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  byte_t             w_rdata;

  // Undriven or unknown enables must never look like a request.
  assign w_rd  = (memory_read_en === 1'b1);
  assign w_wr  = (memory_write_en === 1'b1);
  assign w_req = w_rd | w_wr;

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_oob = |addr[31:ADDR_W];
`else
  assign w_oob = 1'b0;
`endif

  assign w_same  = (w_wr == r_wr) && (addr == r_addr) && (!w_wr || (data_in == r_data));
  assign w_start = w_req && ((r_state == IDLE) || ((r_state == READY) && !w_same));

  // On the capture edge the RAM already sees the new address, so its registered
  // read output is valid one edge later, which WAIT_STATES=0 still honours.
  assign w_ram_we   = w_start && w_wr && !w_oob;
  assign w_ram_addr = w_start ? addr[ADDR_W-1:0] : r_addr[ADDR_W-1:0];

  mem_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (data_in),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_data  <= 8'h00;
      r_wr    <= 1'b0;
      r_oob   <= 1'b0;
      r_ready <= 1'b0;
      r_dout  <= 8'h00;
    end else if (w_start) begin
      r_addr  <= addr;
      r_data  <= data_in;
      r_wr    <= w_wr;
      r_oob   <= w_oob;
      r_cnt   <= 4'(WAIT_STATES);
      r_ready <= 1'b0;
      r_state <= WAIT;
    end else begin
      case (r_state)
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= READY;
            r_ready <= 1'b1;
            if (!r_wr) begin
              r_dout <= r_oob ? 8'h00 : w_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        READY: begin
          if (!w_req) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic r_berr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_berr <= 1'b0;
    end else if (w_start && w_oob) begin
      r_berr <= 1'b1;
    end
  end

  assign bus_error = r_berr;
`else
  assign bus_error = 1'b0;
`endif

  assign memory_ready = r_ready;
  assign data_out     = r_dout;

endmodule
